// File: rtl/ldpc_layer_scheduler.sv
// Layer sequencer for the layered min-sum LDPC decoder: issues one check-node layer
// at a time, folds per-layer parity into an iteration verdict and reports done/fail.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last codeword's iter_count
// ISSUE | layer offered on layer_valid/layer_addr until layer_ready
// WAIT  | layer in flight; waiting for layer_done
// CHECK | end of iteration: bump iter_count, decide stop/continue
// DONE  | one-cycle done pulse with fail status
module ldpc_layer_scheduler #(
  parameter int NUM_LAYERS = 32,
  parameter int LAYER_W    = 5,
  parameter int ITER_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              early_term_en,
  output logic              busy,
  output logic              layer_valid,
  output logic [LAYER_W-1:0] layer_addr,
  input  logic              layer_ready,
  input  logic              layer_done,
  input  logic              layer_parity_ok,
  output logic [ITER_W-1:0] iter_count,
  output logic              done,
  output logic              fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [ITER_W-1:0]  ITER_ONE   = ITER_W'(1);
  localparam logic [ITER_W:0]    ITER_INC   = (ITER_W + 1)'(1);

  state_t            state;
  logic [ITER_W-1:0] max_iter_l;
  logic              early_term_l;
  logic              parity_acc;
  logic [ITER_W:0]   iter_next;

  // Widened by one bit so a limit of 2^ITER_W-1 never wraps the compare.
  assign iter_next = {1'b0, iter_count} + ITER_INC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      max_iter_l   <= ITER_ONE;
      early_term_l <= 1'b0;
      parity_acc   <= 1'b1;
      busy         <= 1'b0;
      layer_valid  <= 1'b0;
      layer_addr   <= '0;
      iter_count   <= '0;
      done         <= 1'b0;
      fail         <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            max_iter_l   <= (max_iter == '0) ? ITER_ONE : max_iter;
            early_term_l <= early_term_en;
            layer_addr   <= '0;
            iter_count   <= '0;
            parity_acc   <= 1'b1;
            busy         <= 1'b1;
            layer_valid  <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (layer_ready) begin
            layer_valid <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (layer_done) begin
            parity_acc <= parity_acc & layer_parity_ok;
            if (layer_addr == LAST_LAYER) begin
              state <= S_CHECK;
            end else begin
              layer_addr  <= layer_addr + 1'b1;
              layer_valid <= 1'b1;
              state       <= S_ISSUE;
            end
          end
        end
        S_CHECK: begin
          iter_count <= iter_next[ITER_W-1:0];
          if (early_term_l && parity_acc) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (iter_next >= {1'b0, max_iter_l}) begin
            done  <= 1'b1;
            fail  <= ~parity_acc;
            state <= S_DONE;
          end else begin
            layer_addr  <= '0;
            parity_acc  <= 1'b1;
            layer_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy        <= 1'b0;
          layer_valid <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
